// File: rtl/risc_pkg.sv
// Shared fetch-stage types and widths.
package risc_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction memory handshake plus decode-facing signals.
interface ifetch_if;

  logic                        imem_req;
  logic [risc_pkg::PC_W-1:0]   imem_addr;
  logic                        imem_ack;
  logic [risc_pkg::INST_W-1:0] imem_rdata;
  logic                        stall;
  logic                        redirect;
  logic [risc_pkg::PC_W-1:0]   redirect_pc;
  logic [risc_pkg::INST_W-1:0] inst;
  logic [risc_pkg::PC_W-1:0]   inst_pc;
  logic                        cnt;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, cnt,
    input  imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, cnt,
    output imem_ack, imem_rdata, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Small instruction buffer; head and valid are registered so decode never sees memory data directly.
module ifetch_fifo
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         nonempty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop_c;
  logic             do_push_c;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [CNT_W-1:0] occ_c;
  logic [CNT_W-1:0] count_nxt_c;
  fetch_entry_t     head_nxt_c;

  // Next head: oldest surviving entry, or the incoming word when it lands in an empty buffer.
  always_comb begin
    do_pop_c     = pop && (count != '0);
    do_push_c    = push && ((count != CNT_W'(DEPTH)) || do_pop_c);
    rd_ptr_nxt_c = rd_ptr + PTR_W'(do_pop_c);
    occ_c        = count - CNT_W'(do_pop_c);
    count_nxt_c  = occ_c + CNT_W'(do_push_c);
    head_nxt_c   = head;
    if (occ_c != '0) begin
      head_nxt_c = mem[rd_ptr_nxt_c];
    end else if (do_push_c) begin
      head_nxt_c = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      nonempty <= 1'b0;
      head     <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt_c;
      count    <= count_nxt_c;
      nonempty <= (count_nxt_c != '0);
      head     <= head_nxt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a time, buffers words for decode.
module ifetch
  import risc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CA_W  = CNT_W + 1;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_nxt;
  logic             req_q;
  logic [PC_W-1:0]  addr_q;
  logic             push_c;
  logic             pop_c;
  logic             flush_c;
  fetch_entry_t     entry_c;
  fetch_entry_t     head;
  logic             nonempty;
  logic [CNT_W-1:0] count;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (entry_c),
    .pop       (pop_c),
    .flush     (flush_c),
    .head      (head),
    .nonempty  (nonempty),
    .count     (count)
  );

  // Next-state, PC update and FIFO control; redirect overrides everything else.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    push_c        = 1'b0;
    flush_c       = 1'b0;
    pop_c         = nonempty && !bus.stall;
    entry_c.pc    = pc;
    entry_c.inst  = bus.imem_rdata;
    case (state)
      IDLE: begin
        if (count < CNT_W'(DEPTH)) state_nxt = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          push_c = 1'b1;
          pc_nxt = pc + PC_W'(PC_STEP);
          // Only keep requesting if the next ack is guaranteed a free slot.
          if ((CA_W'(count) + CA_W'(1) - CA_W'(pop_c)) >= CA_W'(DEPTH)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (pop_c) state_nxt = REQ;
      end
      DISCARD: begin
        if (bus.imem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.redirect) begin
      flush_c = 1'b1;
      push_c  = 1'b0;
      pc_nxt  = {bus.redirect_pc[PC_W-1:2], 2'b00};
      if (((state == REQ) || (state == DISCARD)) && !bus.imem_ack) begin
        state_nxt = DISCARD;
      end else begin
        state_nxt = REQ;
      end
    end
  end

  // imem_addr only moves when a fresh request starts, so it stays put through DISCARD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      req_q <= (state_nxt == REQ) || (state_nxt == DISCARD);
      if (state_nxt == REQ) addr_q <= pc_nxt;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.inst      = head.inst;
  assign bus.inst_pc   = head.pc;
  assign bus.cnt       = nonempty;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: cycle checks on the imem side, scoreboard on the decode side.
module tb_ifetch;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  ifetch_if bus();

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned lat      = 0;
  int unsigned wcnt     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ack after 'lat' wait cycles of a held request.
  always @(posedge clk) begin
    #2;
    if (bus.imem_req === 1'b1 && wcnt >= lat) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = memf(bus.imem_addr);
      wcnt           = 0;
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0BAD_0BAD;
      wcnt           = (bus.imem_req === 1'b1) ? wcnt + 1 : 0;
    end
  end

  // Scoreboard monitor: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.cnt === 1'b1 && bus.stall === 1'b0 && bus.redirect === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst actual_pc=%h required=none", bus.inst_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("sb_inst_pc", bus.inst_pc, mon_pc);
        check("sb_inst", bus.inst, memf(mon_pc));
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (3) step();
    @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_cnt", 32'(bus.cnt), 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);

    step(); rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", 32'(bus.imem_req), 32'd0);

    // Zero-wait streaming.
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("seq_req", 32'(bus.imem_req), 32'd1);
      check("seq_addr", bus.imem_addr, 32'(4 * i));
    end

    // Stall fills the buffer and fetch parks in HOLD.
    step(); bus.stall = 1'b1;
    step();
    @(negedge clk);
    check("hold_req", 32'(bus.imem_req), 32'd0);
    check("hold_cnt", 32'(bus.cnt), 32'd1);
    check("hold_head", bus.inst_pc, 32'hC);
    repeat (3) step();
    @(negedge clk);
    check("hold_req2", 32'(bus.imem_req), 32'd0);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    step(); bus.stall = 1'b0;
    step();
    @(negedge clk);
    check("refill_req", 32'(bus.imem_req), 32'd1);
    check("refill_addr", bus.imem_addr, 32'h14);
    step();
    step(); bus.stall = 1'b1;

    // Flush into a 3-cycle-latency memory.
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h200; lat = 2;
    step(); bus.redirect = 1'b0; bus.stall = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    check("lat_cnt0", 32'(bus.cnt), 32'd0);
    check("lat_addr0", bus.imem_addr, 32'h200);
    step();
    @(negedge clk);
    check("lat_req1", 32'(bus.imem_req), 32'd1);
    check("lat_addr1", bus.imem_addr, 32'h200);
    step();
    @(negedge clk);
    check("lat_addr2", bus.imem_addr, 32'h200);
    check("lat_cnt2", 32'(bus.cnt), 32'd0);
    step();
    @(negedge clk);
    check("lat_cnt3", 32'(bus.cnt), 32'd1);
    check("lat_addr3", bus.imem_addr, 32'h204);
    step();
    @(negedge clk);
    check("lat_cnt4", 32'(bus.cnt), 32'd0);
    step();
    step();
    @(negedge clk);
    check("lat_cnt6", 32'(bus.cnt), 32'd1);

    // Redirect while the request to 0x208 is outstanding.
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    exp_q.push_back(32'h100);
    step(); bus.redirect = 1'b0;
    @(negedge clk);
    check("disc_req", 32'(bus.imem_req), 32'd1);
    check("disc_addr", bus.imem_addr, 32'h208);
    check("disc_cnt", 32'(bus.cnt), 32'd0);
    step();
    @(negedge clk);
    check("disc_new_addr", bus.imem_addr, 32'h100);
    check("disc_cnt1", 32'(bus.cnt), 32'd0);
    step();
    @(negedge clk);
    check("disc_cnt2", 32'(bus.cnt), 32'd0);
    step();
    @(negedge clk);
    check("disc_cnt3", 32'(bus.cnt), 32'd0);
    step();

    // Redirect coinciding with ack and a valid head.
    step(); lat = 0;
    step(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    step(); bus.redirect = 1'b0;
    @(negedge clk);
    check("redir_ack_cnt", 32'(bus.cnt), 32'd0);
    check("redir_ack_req", 32'(bus.imem_req), 32'd1);
    check("redir_ack_addr", bus.imem_addr, 32'h300);
    step();
    step();

    // PC wrap at the top of the address space.
    step(); bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step(); bus.stall = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("wrap_addr2", bus.imem_addr, 32'h0);

    // Reset while a request is waiting.
    step(); lat = 1000;
    step(); rst_n = 1'b0;
    @(negedge clk);
    check("wait_req", 32'(bus.imem_req), 32'd1);
    check("wait_addr", bus.imem_addr, 32'h4);
    step(); rst_n = 1'b1; lat = 0;
    @(negedge clk);
    check("rst2_req", 32'(bus.imem_req), 32'd0);
    check("rst2_cnt", 32'(bus.cnt), 32'd0);
    check("rst2_inst", bus.inst, 32'd0);
    check("rst2_inst_pc", bus.inst_pc, 32'd0);
    exp_q.push_back(32'h0);
    step();
    @(negedge clk);
    check("rst2_fetch_req", 32'(bus.imem_req), 32'd1);
    check("rst2_fetch_addr", bus.imem_addr, 32'h0);
    step();
    step(); bus.stall = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
